// File: rtl/cpu_sequencer_if.sv
// Fetch, ALU-control and strobe bundle between the sequencer and the rest of the CPU.
// master = sequencer side; slave = memory/ALU/datapath side.
interface cpu_sequencer_if #(
   parameter int unsigned PC_W = 11
);
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_rdata;
   logic            imem_valid;
   logic            zr;
   logic            ng;
   logic [5:0]      alu_ctrl;
   logic            load_acc;
   logic            load_mem;
   logic [10:0]     mem_addr;
   logic            retire;
   logic            halted;
   logic            illegal;

   modport master (
      output imem_addr, alu_ctrl, load_acc, load_mem, mem_addr, retire, halted, illegal,
      input  imem_rdata, imem_valid, zr, ng
   );

   modport slave (
      input  imem_addr, alu_ctrl, load_acc, load_mem, mem_addr, retire, halted, illegal,
      output imem_rdata, imem_valid, zr, ng
   );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/EXEC/WB sequencer for the 16-bit accumulator CPU.
// Owns PC, instruction register and the registered ALU flags used by branches.
module cpu_sequencer #(
   parameter int unsigned    PC_W     = 11,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   cpu_sequencer_if.master    bus
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [5:0] ALU_ZERO = 6'b101010;

   state_t          r_state;
   state_t          w_state_next;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_ir;
   logic            r_zr;
   logic            r_ng;
   logic            r_illegal;

   logic [4:0]      w_op;
   logic [5:0]      w_dec;
   logic            w_is_alu;
   logic            w_is_store;
   logic            w_is_halt;
   logic            w_is_illegal;
   logic [PC_W-1:0] w_pc_inc;
   logic [PC_W-1:0] w_target;
   logic [PC_W-1:0] w_pc_next;

   assign w_op         = r_ir[15:11];
   assign w_is_alu     = (w_op <= 5'h12);
   assign w_is_store   = (w_op == 5'h13);
   assign w_is_halt    = (w_op == 5'h17);
   assign w_is_illegal = (w_op >= 5'h18);
   assign w_pc_inc     = r_pc + PC_W'(1);
   assign w_target     = r_ir[PC_W-1:0];

   // ALU control word {zx,nx,zy,ny,f,no}; non-ALU opcodes select constant 0.
   always_comb begin
      w_dec = ALU_ZERO;
      case (w_op)
         5'h00: w_dec = 6'b101010;
         5'h01: w_dec = 6'b111111;
         5'h02: w_dec = 6'b111010;
         5'h03: w_dec = 6'b001100;
         5'h04: w_dec = 6'b110001;
         5'h05: w_dec = 6'b001101;
         5'h06: w_dec = 6'b100001;
         5'h07: w_dec = 6'b001111;
         5'h08: w_dec = 6'b110011;
         5'h09: w_dec = 6'b011111;
         5'h0A: w_dec = 6'b110111;
         5'h0B: w_dec = 6'b001110;
         5'h0C: w_dec = 6'b110010;
         5'h0D: w_dec = 6'b000010;
         5'h0E: w_dec = 6'b010011;
         5'h0F: w_dec = 6'b000111;
         5'h10: w_dec = 6'b000000;
         5'h11: w_dec = 6'b010101;
         default: w_dec = ALU_ZERO;
      endcase
   end

   // Branches test the flags captured at the last ALU write-back, not live zr/ng.
   always_comb begin
      w_pc_next = w_pc_inc;
      case (w_op)
         5'h14: w_pc_next = w_target;
         5'h15: w_pc_next = r_zr ? w_target : w_pc_inc;
         5'h16: w_pc_next = r_ng ? w_target : w_pc_inc;
         5'h17: w_pc_next = r_pc;
         default: w_pc_next = w_pc_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FETCH: if (bus.imem_valid) w_state_next = S_EXEC;
         S_EXEC:  w_state_next = S_WB;
         S_WB:    w_state_next = w_is_halt ? S_HALT : S_FETCH;
         S_HALT:  w_state_next = S_HALT;
         default: w_state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc      <= RESET_PC;
         r_ir      <= '0;
         r_zr      <= 1'b0;
         r_ng      <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         if (r_state == S_FETCH && bus.imem_valid) begin
            r_ir <= bus.imem_rdata;
         end
         if (r_state == S_WB) begin
            r_pc <= w_pc_next;
            if (w_is_alu) begin
               r_zr <= bus.zr;
               r_ng <= bus.ng;
            end
            if (w_is_illegal) begin
               r_illegal <= 1'b1;
            end
         end
      end
   end

   assign bus.imem_addr = r_pc;
   assign bus.mem_addr  = r_ir[10:0];
   assign bus.illegal   = r_illegal;

   always_comb begin
      bus.alu_ctrl = ALU_ZERO;
      bus.load_acc = 1'b0;
      bus.load_mem = 1'b0;
      bus.retire   = 1'b0;
      bus.halted   = 1'b0;
      case (r_state)
         S_EXEC: bus.alu_ctrl = w_dec;
         S_WB: begin
            bus.alu_ctrl = w_dec;
            bus.load_acc = w_is_alu;
            bus.load_mem = w_is_store;
            bus.retire   = 1'b1;
         end
         S_HALT:  bus.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the 16-bit accumulator CPU.
- Owns the PC, instruction register and registered ALU flags.
- Fetches from instruction memory with a valid handshake, then drives the ALU control word (zx,nx,zy,ny,f,no) and the accumulator/memory write strobes.
- Every output is registered or decoded from registered state. No output depends on the clock level.

Parameters:
- PC_W, 11, PC / jump-target width; also the imem_addr width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- imem_addr  out  PC_W  instruction fetch address; always equals the PC.
- imem_rdata  in  16  instruction word: [15:11] opcode, [10:0] operand.
- imem_valid  in  1  imem_rdata is valid this cycle; the memory may insert wait states.
- zr  in  1  ALU result == 0.
- ng  in  1  ALU result < 0.
- alu_ctrl  out  6  {zx,nx,zy,ny,f,no}.
- load_acc  out  1  accumulator write strobe.
- load_mem  out  1  data-memory write strobe.
- mem_addr  out  11  data address, IR[10:0].
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  CPU stopped.
- illegal  out  1  sticky flag: an undefined opcode was executed.

Behaviour:
- Reset (rst_n=0 at an edge), from any state including mid-fetch or HALT:
  - state=FETCH, pc=RESET_PC, IR=0, zr_q=ng_q=0.
  - halted=0, illegal=0, retire=0, load_acc=load_mem=0.
  - alu_ctrl=101010 (constant 0), mem_addr=0.
- FETCH:
  - imem_addr=pc.
  - Stay in FETCH while imem_valid=0.
  - When imem_valid=1: IR<=imem_rdata, go to EXEC.
- EXEC (1 cycle): alu_ctrl decoded from IR[15:11]; strobes 0; go to WB.
- WB (1 cycle):
  - alu_ctrl is held from EXEC.
  - retire=1.
  - Next-PC and strobes per the opcode table below.
  - Go to FETCH, or to HALT for opcode 17.
- HALT: halted=1, all strobes 0, alu_ctrl=101010. Only reset exits HALT.
- Latency: minimum 3 cycles per instruction (FETCH with immediate valid, EXEC, WB), plus one cycle per imem wait state.
- Opcode table, alu_ctrl as zx nx zy ny f no:
  - 00=101010, 01=111111, 02=111010, 03=001100
  - 04=110001, 05=001101, 06=100001, 07=001111
  - 08=110011, 09=011111, 0A=110111, 0B=001110
  - 0C=110010, 0D=000010, 0E=010011, 0F=000111
  - 10=000000, 11=010101, 12=101010
- Opcode 00–12: in WB, load_acc=1, zr_q<=zr, ng_q<=ng, pc<=pc+1.
- Opcode 13 (store): alu_ctrl=101010. In WB, load_mem=1, load_acc=0, flags unchanged, pc<=pc+1.
- Opcode 14 (JMP): pc<=IR[PC_W-1:0].
- Opcode 15 (JZ): pc<=target if zr_q, else pc+1.
- Opcode 16 (JN): pc<=target if ng_q, else pc+1.
- Jump rules (14–16):
  - Tests use the registered flags from the last ALU op, never live zr/ng.
  - alu_ctrl=101010; no strobes; flags unchanged.
- Opcode 17 (HALT): retire=1 in WB, then enter HALT. pc is not incremented.
- Opcodes 18–1F: treated as NOP (pc+1, no strobes), and illegal<=1 (sticky until reset).
- PC arithmetic is modulo 2^PC_W: pc=2^PC_W−1 increments to 0.
- A jump target equal to pc is legal (self-loop).
- load_acc and load_mem are never both 1. Each is high only in WB, for exactly one cycle.
- mem_addr=IR[10:0] whenever the state is not FETCH.

Test Plan:
- Reset, then program {0x0800 (op01), 0x6800 (op0D)} with imem_valid always 1:
  - imem_addr: 0,0,0,1,1,1,2.
  - Op01 EXEC: alu_ctrl=111111.
  - One load_acc pulse per instruction.
  - retire at cycles 3 and 6.
- imem_valid held low 4 cycles during the fetch at pc=5:
  - FETCH lasts 5 cycles; IR is captured only on the valid cycle; no strobes during the wait.
- ALU op with zr=1 in WB, then JZ 0x0123 (0xA923):
  - pc becomes 0x123.
- Repeat the previous case with zr=0 in WB:
  - pc becomes the JZ address + 1.
- Change zr between the ALU op and the JZ:
  - The branch decision follows the registered value.
- Store 0x9855 (op13, addr 0x055):
  - In WB: load_mem=1, load_acc=0, mem_addr=0x055, alu_ctrl=101010.
- Execute 0xB800 (op17):
  - halted=1 from the cycle after WB; pc frozen; no further fetch changes.
- rst_n=0 for one edge while halted:
  - halted=0, pc=0, FETCH resumes.
- Opcode 0x1F at pc=0x7FF (PC_W=11):
  - illegal=1, pc wraps to 0x000.
- rst_n pulsed low during EXEC:
  - No strobe issued; state returns to FETCH at pc=RESET_PC.
